add_sub_multicycle: RTL and testbench
=====================================

Name: add_sub_multicycle

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Generalises the 4-bit ripple add/sub to WIDTH bits, processed CHUNK bits per clock; carry is held in a register between chunks.
- Adds a valid/ready handshake on input and output, a signed saturation mode, and status flags.
- Sits between operand-issue logic and a result consumer in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- CHUNK, 4, bits processed per cycle; must divide WIDTH exactly. CHUNK == WIDTH is legal (single-cycle).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, m, sat are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- m  input  1  mode: 0 = add (A+B), 1 = subtract (A−B).
- sat  input  1  1 = clamp result to signed range on overflow.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- cout  output  1  final carry-out; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow occurred (before saturation).
- zero  output  1  s == 0 (after saturation).
- neg  output  1  s[WIDTH-1] (after saturation).

Behaviour:
- N = WIDTH/CHUNK. The operation is chunk-serial, LSB chunk first.
- Reset:
  - rst asserted → state IDLE immediately (asynchronous), regardless of current state.
  - out_valid=0; s, cout, ovf, zero, neg = 0.
  - Chunk index and carry register cleared.
  - in_ready=0 while rst is high.
  - Reset during RUN or DONE discards the operation; no partial result is ever presented.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a, b, m, sat; set b' = b XOR {WIDTH{m}}, carry = m, idx = 0; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: {c, sum} = a[idx chunk] + b'[idx chunk] + carry; write sum into the result register chunk idx; carry ← c; idx ← idx+1.
  - After the chunk with idx = N−1 is processed, go to DONE.
  - Inputs are ignored while in RUN.
- State DONE:
  - out_valid=1, in_ready=0. s and all flags are registered and held stable until the output handshake.
  - On out_valid & out_ready: go to IDLE; out_valid deasserts on the next cycle.
  - There is no same-cycle accept of new operands; the next accept is possible one cycle after the output handshake.
- Latency:
  - out_valid rises N cycles after the accepting edge.
  - Minimum throughput: one operation per N+2 cycles.
- Flags, computed when entering DONE:
  - raw = chunk-assembled sum.
  - cout = final carry.
  - ovf = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]).
  - If sat && ovf: s = a[MSB] ? {1, 0…0} : {0, 1…1}. Otherwise s = raw.
  - ovf reports 1 even when the result is saturated.
  - zero and neg are computed from the final s.
- Outputs s, cout, ovf, zero and neg hold their last values in IDLE; they are only meaningful while out_valid=1.
- Wrap-around: with sat=0, the result is modulo 2^WIDTH.
- Parameter checks: elaboration fails if WIDTH % CHUNK != 0 or WIDTH < 2.

Test Plan (WIDTH=16, CHUNK=4, N=4):
- Add 0x1234 + 0x0F0F, m=0, sat=0 → s=0x2143, cout=0, ovf=0, zero=0, neg=0; out_valid exactly 4 cycles after accept.
- Sub 0x0005 − 0x0007, m=1 → s=0xFFFE, cout=0, ovf=0, neg=1. Sub 0x1234 − 0x1234 → s=0x0000, cout=1, zero=1.
- Overflow add 0x7FFF + 0x0001: sat=0 → s=0x8000, ovf=1, neg=1; sat=1 → s=0x7FFF, ovf=1, neg=0.
- Overflow sub 0x8000 − 0x0001: sat=0 → s=0x7FFF, cout=1, ovf=1; sat=1 → s=0x8000, ovf=1, neg=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → s and flags stable, in_ready=0, a concurrent in_valid pulse is not accepted. Raise out_ready → IDLE next cycle, then in_ready=1.
- Reset mid-RUN: assert rst after 2 chunks → out_valid=0 and s=0 immediately. Release rst, issue 0x0001 + 0x0001 → s=0x0002 with no residue from the aborted operation.

Source files
------------

// File: rtl/add_sub_multicycle.sv
// Chunk-serial two's-complement adder/subtractor with a valid/ready handshake.
// Operands are processed CHUNK bits per clock, LSB chunk first. The carry between
// chunks is kept in a register. Optional signed saturation and status flags are
// produced when the last chunk completes.
module add_sub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0]  IDX_LAST   = IDXW'(N - 1);
    localparam logic [WIDTH-1:0] SAT_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // Elaboration-time parameter sanity: a partial last chunk or a 1-bit word is
    // not supported.
    if (WIDTH < 2) begin : g_width_check
        $error("add_sub_multicycle: WIDTH must be at least 2");
    end
    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("add_sub_multicycle: CHUNK must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operands. b is stored already inverted for subtract, so the
    // chunk adder never needs to know the mode.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic             sat_reg;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] raw_reg;

    // Combinational chunk datapath and final-result shaping.
    int               lo;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] raw_next;
    logic             ovf_next;
    logic [WIDTH-1:0] s_next;
    logic             is_last;
    logic             accept;

    assign accept  = in_valid & in_ready;
    assign is_last = (state == RUN) && (idx == IDX_LAST);

    // State register; reset forces IDLE immediately from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk N chunks in RUN, wait for consumer in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low for as long as reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = ~rst;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // One chunk of the ripple add, the partially assembled result, and the
    // flags/saturation that apply once the final chunk lands.
    always_comb begin
        lo        = int'(idx) * CHUNK;
        a_shift   = a_reg >> lo;
        b_shift   = bx_reg >> lo;
        chunk_sum = {1'b0, a_shift[CHUNK-1:0]} + {1'b0, b_shift[CHUNK-1:0]}
                  + (CHUNK+1)'(carry);
        raw_next  = (raw_reg & ~(CHUNK_MASK << lo))
                  | (WIDTH'(chunk_sum[CHUNK-1:0]) << lo);
        ovf_next  = (a_reg[WIDTH-1] == bx_reg[WIDTH-1])
                  && (raw_next[WIDTH-1] != a_reg[WIDTH-1]);
        if (sat_reg && ovf_next) begin
            s_next = a_reg[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            s_next = raw_next;
        end
    end

    // Operand capture, per-chunk accumulation, and registering of the result
    // and flags on the last chunk so they stay stable through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            bx_reg  <= '0;
            sat_reg <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            raw_reg <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_reg   <= a;
                bx_reg  <= b ^ {WIDTH{m}};
                sat_reg <= sat;
                carry   <= m;
                idx     <= '0;
            end else if (state == RUN) begin
                raw_reg <= raw_next;
                carry   <= chunk_sum[CHUNK];
                if (is_last) begin
                    idx  <= '0;
                    s    <= s_next;
                    cout <= chunk_sum[CHUNK];
                    ovf  <= ovf_next;
                    zero <= (s_next == '0);
                    neg  <= s_next[WIDTH-1];
                end else begin
                    idx <= idx + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_multicycle.sv
// Directed bench for add_sub_multicycle at WIDTH=16, CHUNK=4: arithmetic cases,
// overflow with and without saturation, output backpressure and reset mid-run.
module tb_add_sub_multicycle;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             m = 1'b0;
    logic             sat = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    int asserts  = 0;
    int failures = 0;

    add_sub_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case the design never responds
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand set while IDLE and let it be accepted on the next edge
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic mv, input logic satv);
        check("in_ready before accept", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        m        = mv;
        sat      = satv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
    endtask

    // Count edges until out_valid, bounded, and check the latency
    task automatic waitDone(input string tag);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, " latency"}, 32'(cnt), 32'(N));
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] es,
                               input logic ec, input logic eo, input logic ez, input logic en);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " s"},         32'(s),         32'(es));
        check({tag, " cout"},      32'(cout),      32'(ec));
        check({tag, " ovf"},       32'(ovf),       32'(eo));
        check({tag, " zero"},      32'(zero),      32'(ez));
        check({tag, " neg"},       32'(neg),       32'(en));
    endtask

    // Complete the output handshake and confirm the return to IDLE
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"},  32'(in_ready),  32'd1);
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic mv, input logic satv, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo, input logic ez, input logic en);
        applyStimulus(av, bv, mv, satv);
        waitDone(tag);
        checkOutput(tag, es, ec, eo, ez, en);
        handshake(tag);
    endtask

    // Directed sequence
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd0);
        check("reset s",         32'(s),         32'd0);
        check("reset flags",     32'({cout, ovf, zero, neg}), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Plain add with backpressure held in DONE
        applyStimulus(16'h1234, 16'h0F0F, 1'b0, 1'b0);
        waitDone("add");
        checkOutput("add", 16'h2143, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                a        = 16'hFFFF;
                b        = 16'hFFFF;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready",  32'(in_ready),  32'd0);
            check("bp s",         32'(s),         32'h2143);
            check("bp flags",     32'({cout, ovf, zero, neg}), 32'd0);
        end
        handshake("bp");
        @(posedge clk);
        #1;
        check("bp no spurious accept", 32'(in_ready), 32'd1);

        // Subtracts
        runOp("sub neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        runOp("sub zero", 16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Overflow with and without saturation
        runOp("ovf add",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        runOp("ovf add sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        runOp("ovf sub sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        runOp("ovf sub",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Wrap-around and sat with no overflow
        runOp("wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        runOp("sat no ovf", 16'h4000, 16'h1000, 1'b0, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after two chunks of an operation; s currently holds 0x5000
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset s",         32'(s),         32'd0);
        check("mid reset in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post reset out_valid", 32'(out_valid), 32'd0);
        runOp("post reset add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
